// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: binary-search conversion per enabled channel, valid/ready result port.
// Optional 4-pass averaging per channel when SAR_ADC_AVG_EN is defined.
module sar_adc_scan_ctrl #(
  parameter int RES        = 8,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 2,
  parameter int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           start_i,
  input  logic           cont_i,
  input  logic [NCH-1:0] ch_mask_i,
  input  logic           cmp_i,
  output logic           sample_o,
  output logic [CW-1:0]  ch_sel_o,
  output logic [RES-1:0] dac_o,
  output logic [RES-1:0] data_o,
  output logic [CW-1:0]  data_ch_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           busy_o
);

  localparam int KW = $clog2(RES);
  localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_OUT} state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] mask_q;
  logic [CW-1:0]  ch_q;
  logic [SW-1:0]  scnt_q;
  logic [KW-1:0]  k_q;
  logic           dec_q;
  logic [RES-1:0] r_q, r_fin, trial_bit;
  logic [RES-1:0] data_q, avg_res;
  logic [CW-1:0]  dch_q;
  logic           start_ok, samp_done, bit_done, pass_last;
  logic           has_next, wrap_ok;
  logic [CW-1:0]  nxt_ch;

  function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (m[i]) lowest_set = CW'(i);
  endfunction

  assign start_ok  = start_i && (ch_mask_i != '0);
  assign samp_done = (scnt_q == SW'(SAMPLE_CYC-1));
  assign bit_done  = dec_q && (k_q == '0);
  assign wrap_ok   = cont_i && (ch_mask_i != '0);

  // next enabled channel above the current one in the latched mask
  always_comb begin
    has_next = 1'b0;
    nxt_ch   = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (mask_q[i] && (i > int'(ch_q))) begin
        has_next = 1'b1;
        nxt_ch   = CW'(i);
      end
  end

  // result with the bit under test resolved by the comparator
  always_comb begin
    r_fin      = r_q;
    r_fin[k_q] = cmp_i;
    trial_bit      = '0;
    trial_bit[k_q] = 1'b1;
  end

`ifdef SAR_ADC_AVG_EN
  logic [1:0]     pass_q;
  logic [RES+1:0] acc_q, acc_sum;

  assign pass_last = (pass_q == 2'd3);
  assign acc_sum   = acc_q + {2'b00, r_fin};
  assign avg_res   = acc_sum[RES+1:2];

  // accumulator restarts with every channel
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pass_q <= '0;
      acc_q  <= '0;
    end else if (state_q == S_IDLE || (state_q == S_OUT && ready_i)) begin
      pass_q <= '0;
      acc_q  <= '0;
    end else if (state_q == S_CONV && bit_done) begin
      pass_q <= pass_q + 2'd1;
      acc_q  <= acc_sum;
    end
  end
`else
  assign pass_last = 1'b1;
  assign avg_res   = r_fin;
`endif

  // state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_SAMPLE;
      S_SAMPLE: if (samp_done) state_d = S_CONV;
      S_CONV:   if (bit_done) state_d = pass_last ? S_OUT : S_SAMPLE;
      S_OUT:    if (ready_i) state_d = (has_next || wrap_ok) ? S_SAMPLE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mask_q <= '0;
      ch_q   <= '0;
      scnt_q <= '0;
      k_q    <= '0;
      dec_q  <= 1'b0;
      r_q    <= '0;
      data_q <= '0;
      dch_q  <= '0;
    end else begin
      scnt_q <= (state_q == S_SAMPLE) ? scnt_q + SW'(1) : '0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            mask_q <= ch_mask_i;
            ch_q   <= lowest_set(ch_mask_i);
          end
        end
        S_SAMPLE: begin
          k_q   <= KW'(RES-1);
          dec_q <= 1'b0;
          r_q   <= '0;
        end
        S_CONV: begin
          dec_q <= ~dec_q;
          if (dec_q) begin
            r_q <= r_fin;
            if (k_q != '0) k_q <= k_q - KW'(1);
          end
          if (bit_done && pass_last) begin
            data_q <= avg_res;
            dch_q  <= ch_q;
          end
        end
        S_OUT: begin
          if (ready_i) begin
            if (has_next) ch_q <= nxt_ch;
            else if (cont_i) begin
              mask_q <= ch_mask_i;
              if (ch_mask_i != '0) ch_q <= lowest_set(ch_mask_i);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // outputs
  always_comb begin
    sample_o  = (state_q == S_SAMPLE);
    valid_o   = (state_q == S_OUT);
    busy_o    = (state_q != S_IDLE);
    dac_o     = (state_q == S_CONV) ? (r_q | trial_bit) : '0;
    ch_sel_o  = ch_q;
    data_o    = data_q;
    data_ch_o = dch_q;
  end

endmodule
